// File: rtl/clk_gate_idle_ctrl.sv
// Idle-driven enable for an OR-type clock gate: stops the clock after a programmable idle run,
// restarts it with a settle window. All outputs are registered alongside the state.
module clk_gate_idle_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              gate_en,
  output logic              clk_rdy,
  output logic [CNT_W-1:0]  gated_cnt
);

  localparam int WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  typedef enum logic [1:0] {RUN, PREGATE, GATED, WAKE} state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WK_W-1:0]   wake_cnt;
  logic              act;
  logic [IDLE_W:0]   idle_nxt;
  logic              thresh_hit;

  assign act = busy | wake_req | force_on;

  // One extra bit so a saturated idle_cnt still compares as >= any threshold.
  assign idle_nxt   = {1'b0, idle_cnt} + (IDLE_W+1)'(1);
  assign thresh_hit = (idle_thresh != '0) && (idle_nxt >= {1'b0, idle_thresh});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      gate_en   <= 1'b0;
      clk_rdy   <= 1'b1;
      gated_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (act) begin
            idle_cnt <= '0;
          end else begin
            if (!(&idle_cnt)) idle_cnt <= idle_cnt + IDLE_W'(1);
            if (thresh_hit) begin
              state   <= PREGATE;
              clk_rdy <= 1'b0;
            end
          end
        end
        PREGATE: begin
          if (act) begin
            state    <= RUN;
            idle_cnt <= '0;
            clk_rdy  <= 1'b1;
          end else begin
            state   <= GATED;
            gate_en <= 1'b1;
            if (!(&gated_cnt)) gated_cnt <= gated_cnt + CNT_W'(1);
          end
        end
        GATED: begin
          if (act) begin
            state    <= WAKE;
            wake_cnt <= '0;
            gate_en  <= 1'b0;
          end
        end
        WAKE: begin
          // Inputs are deliberately ignored here: a wake always runs to completion.
          if (wake_cnt == WK_W'(WAKE_CYC - 1)) begin
            state    <= RUN;
            idle_cnt <= '0;
            clk_rdy  <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + WK_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          idle_cnt <= '0;
          gate_en  <= 1'b0;
          clk_rdy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
